// File: rtl/strela_cfg_pkg.sv
// Shared types and constants for the CGRA column configuration loader.
package strela_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DRAIN = 2'd3
  } cfg_state_e;

  // Configuration width held by a single PE (WORDS_PER_PE * DATA_WIDTH by default).
  localparam int unsigned PE_CONF_BITS = 160;

endpackage

// File: rtl/column_config_loader.sv
// North-edge feeder for one CGRA column: streams configuration words down the
// PE chain using conf_en, and passes run-time north data through when idle.
module column_config_loader
  import strela_cfg_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ROWS         = 4,
  parameter int WORDS_PER_PE = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] cfg_din_i,
  input  logic                  cfg_din_v_i,
  output logic                  cfg_din_r_o,
  input  logic [DATA_WIDTH-1:0] data_din_i,
  input  logic                  data_din_v_i,
  output logic                  data_din_r_o,
  output logic                  pe_clr_o,
  output logic                  pe_conf_en_o,
  output logic [DATA_WIDTH-1:0] pe_dout_o,
  output logic                  pe_dout_v_o,
  input  logic                  pe_dout_r_i
);

  localparam int unsigned NWORDS = ROWS * WORDS_PER_PE;
  localparam int unsigned CW     = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  if (ROWS < 1) begin : g_rows_check
    $error("column_config_loader: ROWS must be >= 1");
  end

  cfg_state_e            r_state;
  cfg_state_e            w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_clr;
  logic                  r_conf_en;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_done;
  logic                  w_accept;

  assign w_accept     = (r_state == LOAD) && cfg_din_v_i;
  assign cfg_din_r_o  = (r_state == LOAD);
  assign busy_o       = (r_state != IDLE);
  assign pe_clr_o     = r_clr;
  assign pe_conf_en_o = r_conf_en;
  assign done_o       = r_done;

  // State register, word counter and registered chain outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_clr     <= 1'b0;
      r_conf_en <= 1'b0;
      r_word    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clr     <= (r_state == IDLE) && start_i;
      r_conf_en <= w_accept;
      r_done    <= (r_state == DRAIN);
      if (w_accept) begin
        r_word <= cfg_din_i;
      end
      if (r_state == CLEAR) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_next = CLEAR;
      CLEAR:   w_next = LOAD;
      LOAD:    if (w_accept && (r_cnt == LAST)) w_next = DRAIN;
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // North data mux: passthrough when idle, config word register otherwise.
  always_comb begin
    pe_dout_o    = r_word;
    pe_dout_v_o  = 1'b0;
    data_din_r_o = 1'b0;
    if (r_state == IDLE) begin
      pe_dout_o    = data_din_i;
      pe_dout_v_o  = data_din_v_i;
      data_din_r_o = pe_dout_r_i;
    end
  end

endmodule

// File: tb/tb_column_config_loader.sv
// Self-checking bench for column_config_loader with a 4-PE chain model.
module tb_column_config_loader;

  localparam int DW   = 32;
  localparam int ROWS = 4;
  localparam int WPP  = 5;
  localparam int NW   = ROWS * WPP;
  localparam int CB   = DW * WPP;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] cfg_din_i = '0;
  logic          cfg_din_v_i = 1'b0;
  logic          cfg_din_r_o;
  logic [DW-1:0] data_din_i = '0;
  logic          data_din_v_i = 1'b0;
  logic          data_din_r_o;
  logic          pe_clr_o;
  logic          pe_conf_en_o;
  logic [DW-1:0] pe_dout_o;
  logic          pe_dout_v_o;
  logic          pe_dout_r_i = 1'b0;

  column_config_loader #(
    .DATA_WIDTH  (DW),
    .ROWS        (ROWS),
    .WORDS_PER_PE(WPP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cfg_din_i   (cfg_din_i),
    .cfg_din_v_i (cfg_din_v_i),
    .cfg_din_r_o (cfg_din_r_o),
    .data_din_i  (data_din_i),
    .data_din_v_i(data_din_v_i),
    .data_din_r_o(data_din_r_o),
    .pe_clr_o    (pe_clr_o),
    .pe_conf_en_o(pe_conf_en_o),
    .pe_dout_o   (pe_dout_o),
    .pe_dout_v_o (pe_dout_v_o),
    .pe_dout_r_i (pe_dout_r_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Chain model: each PE keeps the words delivered to it while conf_en is high.
  logic [CB-1:0] act_cfg [ROWS];
  logic [CB-1:0] exp_cfg [ROWS];
  int            obs_k;
  int            clr_seen;
  int            en_seen;
  logic [DW-1:0] sent_q [$];

  task automatic chk(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    if (pe_clr_o === 1'b1) begin
      obs_k = 0;
      clr_seen++;
      for (int p = 0; p < ROWS; p++) act_cfg[p] = '0;
    end
    if (pe_conf_en_o === 1'b1) begin
      if (obs_k < NW) act_cfg[obs_k / WPP][DW * (obs_k % WPP) +: DW] = pe_dout_o;
      obs_k++;
      en_seen++;
    end
  endtask

  // mode: 0 back-to-back 0x1000+i, 1 valid every other cycle, 2 random valid/data
  task automatic run_load(input int mode, input bit chain_start, input bit leave_started,
                          input int rst_after, input bit start_mid);
    int            sent = 0;
    bit            prev_acc = 1'b0;
    bit            acc;
    bit            finished = 1'b0;
    logic [DW-1:0] prev_word = '0;
    sent_q.delete();
    clr_seen = 0;
    en_seen  = 0;
    if (!chain_start) start_i = 1'b1;
    tick();
    start_i = 1'b0;
    observe();
    chk("clear_clr", pe_clr_o, 1);
    chk("clear_busy", busy_o, 1);
    chk("clear_ready", cfg_din_r_o, 0);
    chk("clear_conf_en", pe_conf_en_o, 0);
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      observe();
      chk("load_conf_en", pe_conf_en_o, prev_acc);
      if (prev_acc) chk("load_dout", pe_dout_o, prev_word);
      chk("load_ready", cfg_din_r_o, 1);
      chk("load_clr", pe_clr_o, 0);
      chk("load_busy", busy_o, 1);
      chk("load_dout_v", pe_dout_v_o, 0);
      chk("load_data_r", data_din_r_o, 0);
      chk("load_done", done_o, 0);
      if (rst_after > 0 && sent == rst_after) begin
        cfg_din_v_i = 1'b0;
        start_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_conf_en", pe_conf_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", cfg_din_r_o, 0);
        chk("rst_clr", pe_clr_o, 0);
        return;
      end
      case (mode)
        0:       cfg_din_v_i = 1'b1;
        1:       cfg_din_v_i = (cyc % 2) == 0;
        default: cfg_din_v_i = 1'($urandom_range(0, 1));
      endcase
      cfg_din_i = (mode == 0) ? DW'(32'h1000 + sent) : DW'($urandom);
      start_i = start_mid && (sent == 7);
      #1;
      acc = cfg_din_v_i && cfg_din_r_o;
      if (acc) begin
        sent_q.push_back(cfg_din_i);
        sent++;
      end
      prev_acc  = acc;
      prev_word = cfg_din_i;
      tick();
      if (acc && sent == NW) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      chk("load_timeout", 0, 1);
      return;
    end
    cfg_din_v_i = 1'b0;
    start_i = 1'b0;
    observe();
    chk("drain_conf_en", pe_conf_en_o, 1);
    chk("drain_dout", pe_dout_o, prev_word);
    chk("drain_ready", cfg_din_r_o, 0);
    chk("drain_busy", busy_o, 1);
    chk("drain_done", done_o, 0);
    tick();
    observe();
    chk("done_pulse", done_o, 1);
    chk("done_busy", busy_o, 0);
    chk("done_conf_en", pe_conf_en_o, 0);
    chk("done_ready", cfg_din_r_o, 0);
    chk("conf_en_count", en_seen, NW);
    chk("clr_count", clr_seen, 1);
    for (int k = 0; k < NW; k++) exp_cfg[k / WPP][DW * (k % WPP) +: DW] = sent_q[k];
    for (int p = 0; p < ROWS; p++) chk($sformatf("pe%0d_cfg", p), act_cfg[p], exp_cfg[p]);
    if (leave_started) begin
      start_i = 1'b1;
    end else begin
      tick();
      chk("done_one_cycle", done_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges
    tick();
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_clr", pe_clr_o, 0);
    chk("rst_conf_en", pe_conf_en_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", cfg_din_r_o, 0);
    rst_i = 1'b0;
    tick();
    chk("idle_busy", busy_o, 0);

    // Passthrough in IDLE
    data_din_i   = 32'hABCD;
    data_din_v_i = 1'b1;
    pe_dout_r_i  = 1'b0;
    #1;
    chk("pass_data_r_lo", data_din_r_o, 0);
    chk("pass_dout", pe_dout_o, 32'hABCD);
    chk("pass_dout_v", pe_dout_v_o, 1);
    pe_dout_r_i = 1'b1;
    #1;
    chk("pass_data_r_hi", data_din_r_o, 1);
    tick();

    run_load(0, 1'b0, 1'b0, 0, 1'b0);   // back-to-back
    run_load(1, 1'b0, 1'b0, 0, 1'b0);   // valid toggling
    run_load(0, 1'b0, 1'b0, 0, 1'b1);   // start during LOAD ignored
    run_load(0, 1'b0, 1'b0, 7, 1'b0);   // reset after word 7
    tick();
    run_load(0, 1'b0, 1'b0, 0, 1'b0);   // full reload after reset
    run_load(2, 1'b0, 1'b1, 0, 1'b0);   // random, start in done cycle
    run_load(2, 1'b1, 1'b0, 0, 1'b0);   // honoured start
    run_load(2, 1'b0, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
